// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared constants and types for the SPI register controller:
//                register addresses, frame length and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Register map (7-bit address field of the SPI frame)
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    // Frame length and bit-counter sizing (counter saturates at FRAME_BITS+1)
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    // Frame-level state machine
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous pin, with
//                rise/fall detection on the last two synchronized samples.
//                SYNC_STAGES must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus one history flop; resets to the pin's idle level
    // so that no spurious edge is reported when reset is released on an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign rise     =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall     = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_ctrl
//  Description : Write-only SPI mode-0 peripheral that commits 16-bit frames
//                (R/W, 7-bit address, 8-bit data) into a small bank of
//                PWM control registers. Pins are oversampled on clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_pulse,
    output logic       err_pulse
);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(FRAME_BITS + 1);

    logic                  w_sclk_rise;
    logic                  w_copi_level;
    logic                  w_ncs_level;
    logic                  w_ncs_rise;
    logic                  w_ncs_fall;
    logic [2:0]            w_unused_edges;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_frame_start;
    logic                  w_shift_en;
    logic                  w_wr_en;
    logic                  w_err_en;

    logic [CNT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_fall_pending;

    logic                  w_rw;
    logic [6:0]            w_addr;
    logic [7:0]            w_data;
    logic                  w_addr_ok;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sclk),
        .sync_out (w_unused_edges[0]),
        .rise     (w_sclk_rise),
        .fall     (w_unused_edges[1])
    );

    // Only the level of copi matters; it is aligned with sclk by equal-depth chains.
    logic [1:0] w_unused_copi_edges;
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (copi),
        .sync_out (w_copi_level),
        .rise     (w_unused_copi_edges[0]),
        .fall     (w_unused_copi_edges[1])
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ncs),
        .sync_out (w_ncs_level),
        .rise     (w_ncs_rise),
        .fall     (w_unused_edges[2])
    );

    assign w_ncs_fall = ~w_ncs_level & ~w_unused_edges[2] ? 1'b0 : w_unused_edges[2];

    assign w_rw      = r_shift[15];
    assign w_addr    = r_shift[14:8];
    assign w_data    = r_shift[7:0];
    assign w_addr_ok = ({25'd0, w_addr} < NUM_REGS);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and commit decode; an ncs rise beats a coincident sclk edge
    always_comb begin
        w_next_state  = r_state;
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_wr_en       = 1'b0;
        w_err_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ncs_fall || r_fall_pending) begin
                    w_frame_start = 1'b1;
                    w_next_state  = SHIFT;
                end
            end
            SHIFT: begin
                if (w_ncs_rise) begin
                    w_next_state = COMMIT;
                end else if (w_sclk_rise && !w_ncs_level) begin
                    w_shift_en = 1'b1;
                end
            end
            COMMIT: begin
                w_next_state = IDLE;
                if (r_bit_cnt == c_cnt_full && w_rw && w_addr_ok) begin
                    w_wr_en = 1'b1;
                end else if (r_bit_cnt == c_cnt_full && !w_rw) begin
                    // Reads are not supported and are dropped without complaint
                    w_err_en = 1'b0;
                end else begin
                    w_err_en = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Frame shifter, saturating bit counter, and memory of an ncs fall seen in COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_fall_pending <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_level};
                if (r_bit_cnt != c_cnt_sat) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (r_state == COMMIT && w_ncs_fall) begin
                r_fall_pending <= 1'b1;
            end else if (r_state == IDLE) begin
                r_fall_pending <= 1'b0;
            end
        end
    end

    // Register bank and status pulses, all driven straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_pulse        <= 1'b0;
            err_pulse       <= 1'b0;
        end else begin
            wr_pulse  <= w_wr_en;
            err_pulse <= w_err_en;
            if (w_wr_en) begin
                case (w_addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= w_data;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= w_data;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= w_data;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= w_data;
                    ADDR_PWM_DUTY:  pwm_duty_cycle  <= w_data;
                    default: ;
                endcase
            end
        end
    end

endmodule : spi_reg_ctrl
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_reg_ctrl
//  Description : Directed self-checking bench for spi_reg_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    localparam int NUM_REGS    = 5;
    localparam int SYNC_STAGES = 2;
    localparam int HALF_SCLK   = 40;   // sclk period = 8 clk periods

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_pulse;
    logic       err_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int err_cnt = 0;
    logic [7:0] exp_regs [NUM_REGS];

    spi_reg_ctrl #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_pulse        (wr_pulse),
        .err_pulse       (err_pulse)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (wr_pulse)  wr_cnt  = wr_cnt + 1;
        if (err_pulse) err_cnt = err_cnt + 1;
    end

    function automatic logic [39:0] act_vec();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] exp_vec();
        return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
    endfunction

    // Drive one frame of nbits, MSB first; ncs rises 3 ns after a clk posedge
    task automatic send_frame(input logic [31:0] bits, input int nbits);
        ncs = 1'b0;
        #(HALF_SCLK);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            #(HALF_SCLK) sclk = 1'b1;
            #(HALF_SCLK) sclk = 1'b0;
        end
        #(HALF_SCLK);
        ncs  = 1'b1;
        copi = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        int wr0, err0;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
        #1;
        for (int i = 0; i < NUM_REGS; i++) begin
            n_tests++;
            if (act_vec()[i*8 +: 8] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h expected 00", i, act_vec()[i*8 +: 8]);
            end
        end
        wr0 = wr_cnt; err0 = err_cnt;
        repeat (100) @(posedge clk);
        #3;
        n_tests++;
        if (wr_cnt - wr0 !== 0) begin
            n_fail++; $display("FAIL reset_idle_wr: got %0d pulses expected 0", wr_cnt - wr0);
        end
        n_tests++;
        if (err_cnt - err0 !== 0) begin
            n_fail++; $display("FAIL reset_idle_err: got %0d pulses expected 0", err_cnt - err0);
        end
    endtask

    task automatic test_single_write();
        int wr0, err0;
        wr0 = wr_cnt; err0 = err_cnt;
        send_frame(32'h80F0, 16);
        exp_regs[0] = 8'hF0;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        n_tests++;
        if (en_reg_out_7_0 !== 8'hF0) begin
            n_fail++; $display("FAIL write_latency: got %h expected f0", en_reg_out_7_0);
        end
        #2;
        settle();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL write_regs: got %h expected %h", act_vec(), exp_vec());
        end
        n_tests++;
        if (wr_cnt - wr0 !== 1) begin
            n_fail++; $display("FAIL write_wr_pulse: got %0d expected 1", wr_cnt - wr0);
        end
        n_tests++;
        if (err_cnt - err0 !== 0) begin
            n_fail++; $display("FAIL write_err_pulse: got %0d expected 0", err_cnt - err0);
        end
    endtask

    task automatic test_back_to_back();
        int wr0, err0;
        wr0 = wr_cnt; err0 = err_cnt;
        send_frame(32'h8480, 16);
        #(4 * HALF_SCLK);
        send_frame(32'h82FF, 16);
        exp_regs[4] = 8'h80;
        exp_regs[2] = 8'hFF;
        settle();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL b2b_regs: got %h expected %h", act_vec(), exp_vec());
        end
        n_tests++;
        if (wr_cnt - wr0 !== 2) begin
            n_fail++; $display("FAIL b2b_wr_pulse: got %0d expected 2", wr_cnt - wr0);
        end
        n_tests++;
        if (err_cnt - err0 !== 0) begin
            n_fail++; $display("FAIL b2b_err_pulse: got %0d expected 0", err_cnt - err0);
        end
    endtask

    task automatic test_rejects();
        logic [31:0] vec_bits [4];
        int          vec_len  [4];
        int wr0, err0;
        vec_bits[0] = 32'h8555;   vec_len[0] = 16;  // address 5 out of range
        vec_bits[1] = 32'h4078;   vec_len[1] = 15;  // short frame
        vec_bits[2] = 32'h101E1;  vec_len[2] = 17;  // long frame
        vec_bits[3] = 32'h0;      vec_len[3] = 0;   // ncs glitch, no clocks
        for (int v = 0; v < 4; v++) begin
            wr0 = wr_cnt; err0 = err_cnt;
            send_frame(vec_bits[v], vec_len[v]);
            settle();
            n_tests++;
            if (err_cnt - err0 !== 1) begin
                n_fail++; $display("FAIL reject%0d_err: got %0d expected 1", v, err_cnt - err0);
            end
            n_tests++;
            if (wr_cnt - wr0 !== 0) begin
                n_fail++; $display("FAIL reject%0d_wr: got %0d expected 0", v, wr_cnt - wr0);
            end
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reject%0d_regs: got %h expected %h", v, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_read();
        int wr0, err0;
        wr0 = wr_cnt; err0 = err_cnt;
        send_frame(32'h0012, 16);
        settle();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL read_regs: got %h expected %h", act_vec(), exp_vec());
        end
        n_tests++;
        if (wr_cnt - wr0 !== 0) begin
            n_fail++; $display("FAIL read_wr: got %0d expected 0", wr_cnt - wr0);
        end
        n_tests++;
        if (err_cnt - err0 !== 0) begin
            n_fail++; $display("FAIL read_err: got %0d expected 0", err_cnt - err0);
        end
    endtask

    task automatic test_idle_sclk();
        int wr0, err0;
        wr0 = wr_cnt; err0 = err_cnt;
        copi = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #(HALF_SCLK) sclk = 1'b1;
            #(HALF_SCLK) sclk = 1'b0;
        end
        copi = 1'b0;
        settle();
        n_tests++;
        if ((wr_cnt - wr0) + (err_cnt - err0) !== 0) begin
            n_fail++; $display("FAIL idle_sclk_pulses: got %0d expected 0", (wr_cnt - wr0) + (err_cnt - err0));
        end
        send_frame(32'h8133, 16);
        exp_regs[1] = 8'h33;
        settle();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL idle_sclk_write: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] frame;
        int wr0, err0;
        frame = 16'h81AA;
        ncs = 1'b0;
        #(HALF_SCLK);
        for (int i = 15; i >= 8; i--) begin
            copi = frame[i];
            #(HALF_SCLK) sclk = 1'b1;
            #(HALF_SCLK) sclk = 1'b0;
        end
        rst_n = 1'b0;
        #(HALF_SCLK);
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
        n_tests++;
        if (act_vec() !== 40'h0) begin
            n_fail++; $display("FAIL midreset_regs: got %h expected 0", act_vec());
        end
        ncs  = 1'b1;
        copi = 1'b0;
        #(HALF_SCLK);
        rst_n = 1'b1;
        wr0 = wr_cnt; err0 = err_cnt;
        settle();
        n_tests++;
        if ((wr_cnt - wr0) + (err_cnt - err0) !== 0) begin
            n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", (wr_cnt - wr0) + (err_cnt - err0));
        end
        n_tests++;
        if (en_reg_out_15_8 !== 8'h00) begin
            n_fail++; $display("FAIL midreset_hold: got %h expected 00", en_reg_out_15_8);
        end
        send_frame(32'h81AA, 16);
        exp_regs[1] = 8'hAA;
        settle();
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL midreset_refill: got %h expected %h", act_vec(), exp_vec());
        end
        n_tests++;
        if (wr_cnt - wr0 !== 1) begin
            n_fail++; $display("FAIL midreset_wr: got %0d expected 1", wr_cnt - wr0);
        end
    endtask

    initial begin
        @(posedge clk);
        #3;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_rejects();
        test_read();
        test_idle_sclk();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_reg_ctrl
`default_nettype wire
